// File: rtl/spi_pkg.sv
// Shared SPI definitions for the host-side controller and the peripheral
// bench model: frame layout constants, controller state encoding and a
// helper that packs a command into a frame.
//   Exports: FRAME_BITS, RW_BIT, ADDR_MSB, DATA_BITS, ADDR_BITS, BIT_CNT_W,
//            spi_state_e, build_frame()
package spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int DATA_BITS  = 8;
  localparam int ADDR_BITS  = ADDR_MSB - DATA_BITS + 1;
  localparam int BIT_CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Frame layout: {rw, addr[6:0], data[7:0]}, transmitted MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 rw,
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] data
  );
    logic [FRAME_BITS-1:0] frame;
    frame                         = '0;
    frame[RW_BIT]                 = rw;
    frame[ADDR_MSB:DATA_BITS]     = addr;
    frame[DATA_BITS-1:0]          = data;
    return frame;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer. Counts system clocks while run is high and emits
// a one-cycle tick on the last clock of every CLK_DIV-cycle interval. The
// count is held at zero while run is low, so the first tick after run rises
// arrives exactly CLK_DIV cycles later.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : enable; counter cleared while low
//   tick : strobe on the terminal count
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int              CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == TERM);

endmodule

// File: rtl/spi_ctrl_tx.sv
// SPI mode-0 controller: serialises one 16-bit {rw, addr, data} frame per
// accepted command, MSB first, and captures the 8 bits returned on cipo
// during the data half of the frame.
//   clk, rst            : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready registered, high in IDLE)
//   cmd_rw/addr/wdata   : frame contents
//   sclk, copi, ncs     : SPI outputs (sclk idles low, ncs active low)
//   cipo                : SPI input from the peripheral
//   rsp_valid           : one-cycle pulse when the frame completes
//   rsp_rdata           : captured data bits, held until the next rsp_valid
//   busy                : high from accept through the end of the gap
module spi_ctrl_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rw,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_wdata,
  output logic                 sclk,
  output logic                 copi,
  output logic                 ncs,
  input  logic                 cipo,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] RX_FIRST = BIT_CNT_W'(FRAME_BITS - DATA_BITS);

  spi_state_e             state;
  logic [FRAME_BITS-1:0]  tx_sr;
  logic [DATA_BITS-1:0]   rx_sr;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   tick;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .run  (state != ST_IDLE),
    .tick (tick)
  );

  // copi is the top flop of the shift register. Zeros are shifted in, so
  // after the 16th bit the line returns to 0 without extra logic, and it
  // only ever moves on the falling-edge clock.
  assign copi = tx_sr[FRAME_BITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b0;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
    end else begin
      // NOTE: pulse outputs get their idle value first; the single state
      // that raises them overrides it below.
      rsp_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state     <= ST_SETUP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            ncs       <= 1'b0;
            tx_sr     <= build_frame(cmd_rw, cmd_addr, cmd_wdata);
            bit_cnt   <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: cipo still holds the bit launched at the
              // previous falling edge, so sample before advancing copi.
              sclk <= 1'b0;
              if (bit_cnt >= RX_FIRST) begin
                rx_sr <= {rx_sr[DATA_BITS-2:0], cipo};
              end
              tx_sr   <= {tx_sr[FRAME_BITS-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == LAST_BIT) begin
                state <= ST_HOLD;
              end
            end
          end
        end

        ST_HOLD: begin
          if (tick) begin
            ncs       <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= rx_sr;
            state     <= ST_GAP;
          end
        end

        ST_GAP: begin
          if (tick) begin
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
